// File: rtl/scaler_line_buffer_write_if.sv
// Bundles the pixel input stream, the line RAM write port and the reader handshake
// of the scaler line buffer write controller.
interface scaler_line_buffer_write_if #(
  parameter int KERNEL_MAX          = 4,
  parameter int RAM_NUM             = KERNEL_MAX + 1,
  parameter int RAM_NUM_BITWIDTH    = $clog2(RAM_NUM),
  parameter int RAM_DATA_BITWIDTH   = 8,
  parameter int RAM_ADDR_BITWIDTH   = 11,
  parameter int LINE_WIDTH_BITWIDTH = 12
);
  logic [LINE_WIDTH_BITWIDTH-1:0] cfg_line_width;
  logic                           pix_in_valid;
  logic                           pix_in_sof;
  logic [RAM_DATA_BITWIDTH-1:0]   pix_in_data;
  logic                           pix_in_ready;
  logic [RAM_NUM-1:0]             ram_write_en;
  logic [RAM_ADDR_BITWIDTH-1:0]   ram_write_addr;
  logic [RAM_DATA_BITWIDTH-1:0]   ram_write_data;
  logic                           line_release;
  logic [RAM_NUM_BITWIDTH-1:0]    lines_avail;
  logic                           wr_line_done;
  logic [RAM_NUM_BITWIDTH-1:0]    wr_ram_idx;
  logic [1:0]                     err_sticky;

  modport master (
    output cfg_line_width, pix_in_valid, pix_in_sof, pix_in_data, line_release,
    input  pix_in_ready, ram_write_en, ram_write_addr, ram_write_data,
           lines_avail, wr_line_done, wr_ram_idx, err_sticky
  );

  modport slave (
    input  cfg_line_width, pix_in_valid, pix_in_sof, pix_in_data, line_release,
    output pix_in_ready, ram_write_en, ram_write_addr, ram_write_data,
           lines_avail, wr_line_done, wr_ram_idx, err_sticky
  );
endinterface

// File: rtl/scaler_line_buffer_write.sv
// Write side of the scaler's rotating line buffer: fills RAM_NUM line RAMs round-robin
// and tracks how many completed lines the reader still holds.
module scaler_line_buffer_write #(
  parameter int KERNEL_MAX          = 4,
  parameter int RAM_NUM             = KERNEL_MAX + 1,
  parameter int RAM_NUM_BITWIDTH    = $clog2(RAM_NUM),
  parameter int RAM_DATA_BITWIDTH   = 8,
  parameter int RAM_ADDR_BITWIDTH   = 11,
  parameter int LINE_WIDTH_BITWIDTH = 12
) (
  input logic                      core_clk,
  input logic                      core_rst_n,
  scaler_line_buffer_write_if.slave bus
);

  localparam logic [RAM_NUM_BITWIDTH-1:0]    LinesFull = RAM_NUM_BITWIDTH'(RAM_NUM);
  localparam logic [RAM_NUM_BITWIDTH-1:0]    LastIdx   = RAM_NUM_BITWIDTH'(RAM_NUM - 1);
  localparam logic [RAM_NUM_BITWIDTH-1:0]    OneIdx    = RAM_NUM_BITWIDTH'(1);
  localparam logic [LINE_WIDTH_BITWIDTH-1:0] OneCol    = LINE_WIDTH_BITWIDTH'(1);
  localparam logic [RAM_NUM-1:0]             OneHot0   = RAM_NUM'(1);

  typedef enum logic {IDLE, FILL} state_e;

  state_e                         state_q, state_d;
  logic [LINE_WIDTH_BITWIDTH-1:0] width_q, width_d;
  logic [LINE_WIDTH_BITWIDTH-1:0] x_q, x_d;
  logic [RAM_NUM_BITWIDTH-1:0]    idx_q, idx_d;
  logic [RAM_NUM_BITWIDTH-1:0]    lines_q, lines_d;
  logic [RAM_NUM-1:0]             wen_q, wen_d;
  logic [RAM_ADDR_BITWIDTH-1:0]   waddr_q, waddr_d;
  logic [RAM_DATA_BITWIDTH-1:0]   wdata_q, wdata_d;
  logic                           done_q, done_d;
  logic [1:0]                     err_q, err_d;

  logic                           ready;
  logic                           accept;
  logic                           sofAcc;
  logic                           doWrite;
  logic                           lineEnd;
  logic [LINE_WIDTH_BITWIDTH-1:0] effWidth;
  logic [LINE_WIDTH_BITWIDTH-1:0] effX;
  logic [RAM_NUM_BITWIDTH-1:0]    effIdx;

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q <= IDLE;
      width_q <= '0;
      x_q     <= '0;
      idx_q   <= '0;
      lines_q <= '0;
      wen_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      width_q <= width_d;
      x_q     <= x_d;
      idx_q   <= idx_d;
      lines_q <= lines_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // An accepted SOF is treated as pixel 0 of a fresh frame, so a width-1 frame completes a line at once.
  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    x_d      = x_q;
    idx_d    = idx_q;
    lines_d  = lines_q;
    wen_d    = '0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    err_d    = err_q;

    accept   = bus.pix_in_valid & ready;
    sofAcc   = accept & bus.pix_in_sof;
    effWidth = bus.pix_in_sof ? bus.cfg_line_width : width_q;
    effX     = bus.pix_in_sof ? '0 : x_q;
    effIdx   = bus.pix_in_sof ? '0 : idx_q;
    doWrite  = accept & (bus.pix_in_sof ? (bus.cfg_line_width != '0) : (state_q == FILL));
    lineEnd  = doWrite & (effX == effWidth - OneCol);

    if (sofAcc) begin
      if ((state_q == FILL) && (x_q != '0)) begin
        err_d[0] = 1'b1;
      end
      width_d = bus.cfg_line_width;
      x_d     = '0;
      idx_d   = '0;
      lines_d = '0;
      state_d = (bus.cfg_line_width != '0) ? FILL : IDLE;
    end

    if (doWrite) begin
      wen_d   = OneHot0 << effIdx;
      waddr_d = effX[RAM_ADDR_BITWIDTH-1:0];
      wdata_d = bus.pix_in_data;
      if (lineEnd) begin
        x_d    = '0;
        idx_d  = (effIdx == LastIdx) ? '0 : effIdx + OneIdx;
        done_d = 1'b1;
      end else begin
        x_d = effX + OneCol;
      end
    end

    // A release landing on a line end cancels out; one landing on an SOF is lost in the clear.
    if (sofAcc) begin
      if (lineEnd) begin
        lines_d = OneIdx;
      end
    end else if (lineEnd && !bus.line_release) begin
      lines_d = lines_q + OneIdx;
    end else if (!lineEnd && bus.line_release) begin
      if (lines_q == '0) begin
        err_d[1] = 1'b1;
      end else begin
        lines_d = lines_q - OneIdx;
      end
    end
  end

  always_comb begin
    ready              = core_rst_n && ((state_q == IDLE) || (lines_q != LinesFull));
    bus.pix_in_ready   = ready;
    bus.ram_write_en   = wen_q;
    bus.ram_write_addr = waddr_q;
    bus.ram_write_data = wdata_q;
    bus.lines_avail    = lines_q;
    bus.wr_line_done   = done_q;
    bus.wr_ram_idx     = idx_q;
    bus.err_sticky     = err_q;
  end

endmodule
